// File: rtl/ibr128_ctr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ibr128_ctr_sequencer
// Brief    : Drives the IBR128 64-bit pipelined adder to produce CTR-mode
//            counter blocks IV+0 .. IV+N-1 on a valid/ready output port.
//            Operands are held stable for ADD_LAT enabled edges per sum so
//            that carries ripple through every adder lane.
// Revision : 1.0 - initial release
// ============================================================================
module ibr128_ctr_sequencer #(
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic             Abort,
  input  logic [63:0]      IV,
  input  logic [CNT_W-1:0] NumBlocks,
  output logic             AddEnable,
  output logic [63:0]      AddA,
  output logic [63:0]      AddB,
  input  logic [63:0]      AddS,
  output logic [63:0]      CtrBlock,
  output logic             CtrValid,
  input  logic             CtrReady,
  output logic [CNT_W-1:0] BlkIdx,
  output logic             Busy,
  output logic             Done
);

  localparam int               c_lat_w    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(ADD_LAT - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_add  = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;
  localparam logic [1:0] c_st_fin  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [63:0]        iv_q, iv_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [c_lat_w-1:0] lat_q, lat_d;

  logic w_hshk;
  logic w_last_blk;
  logic w_lat_done;

  assign w_hshk     = (state_q == c_st_out) && CtrReady;
  assign w_last_blk = (idx_q == (num_q - CNT_W'(1)));
  assign w_lat_done = (lat_q == c_lat_last);

  // State register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = c_st_idle;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (Start) begin
            state_d = (NumBlocks == '0) ? c_st_fin : c_st_add;
          end
        end
        c_st_add: begin
          if (w_lat_done) begin
            state_d = c_st_out;
          end
        end
        c_st_out: begin
          if (CtrReady) begin
            state_d = w_last_blk ? c_st_fin : c_st_add;
          end
        end
        default: state_d = c_st_idle;
      endcase
    end
  end

  // Datapath registers: latched IV, block count, block index, latency counter.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      iv_q  <= '0;
      num_q <= '0;
      idx_q <= '0;
      lat_q <= '0;
    end else begin
      iv_q  <= iv_d;
      num_q <= num_d;
      idx_q <= idx_d;
      lat_q <= lat_d;
    end
  end

  // Datapath next values; operands stay frozen while the adder settles.
  always_comb begin
    iv_d  = iv_q;
    num_d = num_q;
    idx_d = idx_q;
    lat_d = lat_q;
    if (!Abort) begin
      case (state_q)
        c_st_idle: begin
          if (Start) begin
            iv_d  = IV;
            num_d = NumBlocks;
            idx_d = '0;
            lat_d = '0;
          end
        end
        c_st_add: begin
          lat_d = w_lat_done ? '0 : lat_q + c_lat_w'(1);
        end
        c_st_out: begin
          if (w_hshk && !w_last_blk) begin
            idx_d = idx_q + CNT_W'(1);
            lat_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; adder is frozen in OUT so CtrBlock holds until handshake.
  always_comb begin
    AddEnable           = (state_q == c_st_add);
    AddA                = iv_q;
    AddB                = '0;
    AddB[CNT_W-1:0]     = idx_q;
    CtrValid            = (state_q == c_st_out);
    CtrBlock            = (state_q == c_st_out) ? AddS : '0;
    BlkIdx              = idx_q;
    Busy                = (state_q != c_st_idle);
    Done                = (state_q == c_st_fin);
  end

endmodule
`default_nettype wire

// File: tb/tb_ibr128_ctr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibr128_ctr_sequencer
// Brief    : Self-checking bench for ibr128_ctr_sequencer with a pipelined
//            adder model and a transaction-level expected-block reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibr128_ctr_sequencer;

  localparam int ADD_LAT = 4;
  localparam int CNT_W   = 32;

  logic             Clk = 1'b0;
  logic             RstN = 1'b0;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic             CtrReady = 1'b0;
  logic [63:0]      IV = '0;
  logic [CNT_W-1:0] NumBlocks = '0;
  logic [63:0]      AddS;
  logic             AddEnable;
  logic [63:0]      AddA;
  logic [63:0]      AddB;
  logic [63:0]      CtrBlock;
  logic             CtrValid;
  logic [CNT_W-1:0] BlkIdx;
  logic             Busy;
  logic             Done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_iv = '0;

  always #5 Clk = ~Clk;

  ibr128_ctr_sequencer #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .RstN(RstN), .Start(Start), .Abort(Abort), .IV(IV),
    .NumBlocks(NumBlocks), .AddEnable(AddEnable), .AddA(AddA), .AddB(AddB),
    .AddS(AddS), .CtrBlock(CtrBlock), .CtrValid(CtrValid), .CtrReady(CtrReady),
    .BlkIdx(BlkIdx), .Busy(Busy), .Done(Done)
  );

  // Adder model: a sum needs ADD_LAT enabled edges with stable operands.
  logic [63:0] pipe [ADD_LAT];
  initial for (int k = 0; k < ADD_LAT; k++) pipe[k] = {$urandom, $urandom};
  always @(posedge Clk) begin
    if (AddEnable) begin
      pipe[0] <= AddA + AddB;
      for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign AddS = pipe[ADD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    64'(AddEnable), 64'd0);
    chk({tag, "_a"},     AddA,           64'd0);
    chk({tag, "_b"},     AddB,           64'd0);
    chk({tag, "_blk"},   CtrBlock,       64'd0);
    chk({tag, "_valid"}, 64'(CtrValid),  64'd0);
    chk({tag, "_idx"},   64'(BlkIdx),    64'd0);
    chk({tag, "_busy"},  64'(Busy),      64'd0);
    chk({tag, "_done"},  64'(Done),      64'd0);
  endtask

  // Advance one cycle, or inject an Abort when the scheduled cycle arrives.
  task automatic tick(inout int cyc, input int abort_cyc, output bit ab);
    ab = 1'b0;
    if (cyc == abort_cyc) begin
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      Start = 1'b0;
      chk("abort_busy",  64'(Busy),      64'd0);
      chk("abort_valid", 64'(CtrValid),  64'd0);
      chk("abort_en",    64'(AddEnable), 64'd0);
      chk("abort_done",  64'(Done),      64'd0);
      @(negedge Clk);
      chk("abort_done2", 64'(Done),      64'd0);
      ab = 1'b1;
    end else begin
      @(negedge Clk);
      Start = 1'b0;
      cyc++;
    end
  endtask

  // One operation: expected blocks are iv+i mod 2^64, ADD_LAT cycles of
  // adder enable before each block, then OUT until the handshake.
  task automatic run_op(input logic [63:0] iv, input int n, input int rdy_pct,
                        input int min_stall, input int abort_cyc, input bit poke);
    int cyc;
    int stalls;
    bit r;
    bit ab;
    cyc = 0;
    Start = 1'b1;
    IV = iv;
    NumBlocks = CNT_W'(n);
    @(negedge Clk);
    Start = 1'b0;
    IV = {$urandom, $urandom};
    NumBlocks = CNT_W'($urandom);
    last_iv = iv;
    if (n == 0) begin
      chk("n0_done",  64'(Done),     64'd1);
      chk("n0_valid", 64'(CtrValid), 64'd0);
      @(negedge Clk);
      chk("n0_busy",  64'(Busy),     64'd0);
      chk("n0_done2", 64'(Done),     64'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ADD_LAT; k++) begin
        chk("add_en",    64'(AddEnable), 64'd1);
        chk("add_valid", 64'(CtrValid),  64'd0);
        chk("add_blk",   CtrBlock,       64'd0);
        chk("add_a",     AddA,           iv);
        chk("add_b",     AddB,           64'(i));
        chk("add_busy",  64'(Busy),      64'd1);
        if (poke && k == 1) begin
          Start = 1'b1;
          IV = {$urandom, $urandom};
          NumBlocks = CNT_W'($urandom_range(9, 1));
        end
        tick(cyc, abort_cyc, ab);
        if (ab) return;
      end
      stalls = 0;
      do begin
        chk("out_valid", 64'(CtrValid),  64'd1);
        chk("out_block", CtrBlock,       iv + 64'(i));
        chk("out_idx",   64'(BlkIdx),    64'(i));
        chk("out_en",    64'(AddEnable), 64'd0);
        chk("out_done",  64'(Done),      64'd0);
        r = (stalls >= min_stall) && ((stalls >= 12) || ($urandom_range(99) < rdy_pct));
        CtrReady = r;
        stalls++;
        tick(cyc, abort_cyc, ab);
        if (ab) begin
          CtrReady = 1'b0;
          return;
        end
      end while (!r);
      CtrReady = 1'b0;
    end
    chk("fin_done",  64'(Done),     64'd1);
    chk("fin_valid", 64'(CtrValid), 64'd0);
    @(negedge Clk);
    chk("idle_done", 64'(Done),     64'd0);
    chk("idle_busy", 64'(Busy),     64'd0);
  endtask

  initial begin
    int  n;
    int  pct;
    int  abc;
    bit  seen;
    logic [63:0] riv;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge Clk);
    RstN = 1'b1;
    @(negedge Clk);

    // T1..T4 directed sequences
    run_op(64'h0000_0000_0000_0010, 3, 100, 0, -1, 1'b0);
    run_op(64'h0000_0000_FFFF_FFFF, 2, 100, 0, -1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 2, 100, 0, -1, 1'b0);
    run_op(64'h0000_0000_0000_0100, 2, 100, 7, -1, 1'b0);

    // T5: empty run, then Start pulses while busy
    run_op(64'h0000_0000_0000_0777, 0, 100, 0, -1, 1'b0);
    run_op(64'h0000_0000_0000_0020, 3, 100, 0, -1, 1'b1);

    // T6: abort in ADD of block 1, then a clean single block
    run_op(64'h0000_0000_0000_0040, 3, 100, 0, 6, 1'b0);
    run_op(64'h0000_0000_0000_0005, 1, 100, 0, -1, 1'b0);

    // Start together with Abort in IDLE latches nothing
    Start = 1'b1;
    Abort = 1'b1;
    IV = 64'hDEAD_BEEF_0000_0001;
    NumBlocks = CNT_W'(3);
    @(negedge Clk);
    Start = 1'b0;
    Abort = 1'b0;
    chk("sa_busy", 64'(Busy), 64'd0);
    chk("sa_a",    AddA,      last_iv);
    @(negedge Clk);
    chk("sa_busy2", 64'(Busy), 64'd0);

    // Reset asserted in OUT clears everything immediately
    Start = 1'b1;
    IV = 64'h0000_0000_0000_0ABC;
    NumBlocks = CNT_W'(3);
    @(negedge Clk);
    Start = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (CtrValid) seen = 1'b1;
      else @(negedge Clk);
    end
    chk("rst_wait_valid", 64'(seen), 64'd1);
    RstN = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    last_iv = '0;
    @(negedge Clk);
    RstN = 1'b1;
    @(negedge Clk);
    run_op(64'h0000_0000_0000_0005, 1, 100, 0, -1, 1'b0);

    // Randomized operations
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(3))
        0:       riv = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(3));
        1:       riv = {32'h0, 32'hFFFF_FFFF - 32'($urandom_range(3))};
        default: riv = {$urandom, $urandom};
      endcase
      n   = $urandom_range(4);
      pct = $urandom_range(100, 40);
      abc = ($urandom_range(4) == 0) ? $urandom_range(14) : -1;
      run_op(riv, n, pct, 0, abc, 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) @(negedge Clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
